// File: rtl/serial_prod_accum.sv
// Recirculating delay-line accumulator with a bit-serial adder/subtractor, per-word shifts and one carry FF.
// Optional zero detection of the written result is built when G15_ACCUM_ZERO_DET_EN is defined.
module serial_prod_accum #(
  parameter int WORD_BITS = 29,
  parameter int WORDS     = 2
) (
  input  logic                                          CLOCK,
  input  logic                                          rst,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic [2:0]                                    cmd_op,
  input  logic [$clog2(WORDS+1)-1:0]                    cmd_words,
  input  logic                                          ser_in,
  output logic                                          acc_out,
  output logic [$clog2(WORD_BITS)-1:0]                  bit_pos,
  output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0]  word_pos,
  output logic                                          done,
  output logic                                          carry_out,
  output logic                                          ovf,
  output logic                                          acc_zero
);

  localparam int N    = WORD_BITS * WORDS;
  localparam int BP_W = $clog2(WORD_BITS);
  localparam int WP_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW_W = $clog2(WORDS + 1);
  localparam logic [BP_W-1:0] BIT_LAST  = BP_W'(WORD_BITS - 1);
  localparam logic [WP_W-1:0] WORD_LAST = WP_W'(WORDS - 1);
  localparam logic [CW_W-1:0] WORDS_MAX = CW_W'(WORDS);

  typedef enum logic [2:0] {
    OP_NOP, OP_CLEAR, OP_LOAD, OP_ADD, OP_SUB, OP_SHR, OP_SHRL, OP_RSVD
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} state_e;

  state_e          state;
  op_e             op_q;
  logic [WP_W-1:0] last_word_q, last_word_d;
  logic [N-1:0]    track;
  logic            carry;
  logic            tap0, tap1;
  logic            at_origin, at_wrap, exec_en, first_bit, exec_end, is_arith;
  logic            operand, c_in, c_maj, sum, new_bit;

  // tap0 is the bit being rewritten this cycle, tap1 the next bit of the same word.
  assign tap0      = track[N-1];
  assign tap1      = track[N-2];
  assign acc_out   = tap0;
  assign cmd_ready = (state == S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a value on every path (new_bit defaults first), so no latch is inferred.
    at_origin = (bit_pos == '0) && (word_pos == '0);
    at_wrap   = (bit_pos == BIT_LAST) && (word_pos == WORD_LAST);
    exec_en   = (state == S_EXEC);
    first_bit = exec_en && at_origin;
    exec_end  = exec_en && (bit_pos == BIT_LAST) && (word_pos == last_word_q);
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    operand   = ser_in ^ (op_q == OP_SUB);
    c_in      = first_bit ? (op_q == OP_SUB) : carry;
    sum       = tap0 ^ operand ^ c_in;
    c_maj     = (tap0 & operand) | (tap0 & c_in) | (operand & c_in);

    new_bit = tap0;
    if (exec_en) begin
      case (op_q)
        OP_CLEAR:       new_bit = 1'b0;
        OP_LOAD:        new_bit = ser_in;
        OP_ADD, OP_SUB: new_bit = sum;
        OP_SHR:         new_bit = (bit_pos == BIT_LAST) ? tap0 : tap1;
        OP_SHRL:        new_bit = (bit_pos == BIT_LAST) ? 1'b0 : tap1;
        default:        new_bit = tap0;
      endcase
    end

    // A zero or oversized word count selects the whole track.
    if ((cmd_words == '0) || (cmd_words > WORDS_MAX)) last_word_d = WORD_LAST;
    else                                              last_word_d = WP_W'(cmd_words - 1'b1);
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      bit_pos  <= '0;
      word_pos <= '0;
    end else if (bit_pos == BIT_LAST) begin
      bit_pos  <= '0;
      word_pos <= (word_pos == WORD_LAST) ? '0 : word_pos + 1'b1;
    end else begin
      bit_pos <= bit_pos + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    // NOTE: the track is a shift register, not a RAM, so it is reset to zero like any other flop.
    if (rst) begin
      track <= '0;
      carry <= 1'b0;
    end else begin
      track <= {track[N-2:0], new_bit};
      if (exec_en && is_arith) carry <= c_maj;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      last_word_q <= '0;
      done        <= 1'b0;
      carry_out   <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q        <= op_e'(cmd_op);
          last_word_q <= last_word_d;
          state       <= at_wrap ? S_EXEC : S_WAIT;
        end
        S_WAIT: if (at_wrap) state <= S_EXEC;
        S_EXEC: if (exec_end) begin
          state     <= S_DONE;
          done      <= 1'b1;
          carry_out <= is_arith ? c_maj : carry;
          ovf       <= is_arith & (c_in ^ c_maj);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef G15_ACCUM_ZERO_DET_EN
  logic zero_run, zero_next;

  assign zero_next = (first_bit | zero_run) & ~new_bit;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      zero_run <= 1'b0;
      acc_zero <= 1'b0;
    end else if (exec_en) begin
      zero_run <= zero_next;
      if (exec_end) acc_zero <= zero_next;
    end
  end
`else
  assign acc_zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_prod_accum.sv
// Directed self-checking bench for serial_prod_accum (WORD_BITS=29, WORDS=2).
module tb_serial_prod_accum;

  localparam int WB  = 29;
  localparam int WDS = 2;
  localparam int N   = WB * WDS;

  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_SHR   = 3'd5;
  localparam logic [2:0] OP_SHRL  = 3'd6;

`ifdef G15_ACCUM_ZERO_DET_EN
  localparam logic ZD_EN = 1'b1;
`else
  localparam logic ZD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_words;
  logic       ser_in;
  logic       acc_out;
  logic [4:0] bit_pos;
  logic [0:0] word_pos;
  logic       done, carry_out, ovf, acc_zero;

  int checks = 0;
  int errors = 0;

  serial_prod_accum #(.WORD_BITS(WB), .WORDS(WDS)) dut (
    .CLOCK(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_words(cmd_words), .ser_in(ser_in), .acc_out(acc_out),
    .bit_pos(bit_pos), .word_pos(word_pos), .done(done), .carry_out(carry_out),
    .ovf(ovf), .acc_zero(acc_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] trk(input logic [WB-1:0] w1, input logic [WB-1:0] w0);
    return {w1, w0};
  endfunction

  // Captures the whole track, LSB of word 0 first, starting at the next origin.
  task automatic read_track(output logic [N-1:0] v);
    bit found = 1'b0;
    v = '0;
    for (int c = 0; c <= N && !found; c++) begin
      @(negedge clk);
      if (bit_pos == '0 && word_pos == '0) found = 1'b1;
    end
    check("origin_seen", 64'(found), 64'd1);
    for (int i = 0; i < N; i++) begin
      v[i] = acc_out;
      @(negedge clk);
    end
  endtask

  // Issues one command, streams opnd aligned to bit/word position, and waits for done.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] words,
                         input logic [N-1:0] opnd, output int exec_len);
    int start = -1;
    bit got   = 1'b0;
    exec_len  = -1;
    @(negedge clk);
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_words = words;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < 3 * N && !got; c++) begin
      @(negedge clk);
      if (start < 0 && bit_pos == '0 && word_pos == '0) start = c;
      ser_in = opnd[int'(word_pos) * WB + int'(bit_pos)];
      if (done) begin
        got      = 1'b1;
        exec_len = c - start;
      end
    end
    ser_in = 1'b0;
    check("done_seen", 64'(got), 64'd1);
  endtask

  initial begin
    logic [N-1:0] v;
    int           len;
    int           dn;
    bit           found;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_words = '0; ser_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",     64'(cmd_ready), 64'd1);
    check("rst_done",      64'(done),      64'd0);
    check("rst_acc_out",   64'(acc_out),   64'd0);
    check("rst_carry_out", 64'(carry_out), 64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_acc_zero",  64'(acc_zero),  64'd0);
    check("rst_bit_pos",   64'(bit_pos),   64'd0);
    check("rst_word_pos",  64'(word_pos),  64'd0);
    rst = 1'b0;

    // Fill both words, then CLEAR the full track.
    run_cmd(OP_LOAD, 2'd0, trk(29'h0ABCDEF, 29'h1234567), len);
    read_track(v);
    check("load_two_words", 64'(v), 64'(trk(29'h0ABCDEF, 29'h1234567)));
    run_cmd(OP_CLEAR, 2'd0, '0, len);
    check("clear_exec_len",  64'(len), 64'd58);
    check("clear_carry_out", 64'(carry_out), 64'd0);
    check("clear_ovf",       64'(ovf), 64'd0);
    read_track(v);
    check("clear_track", 64'(v), 64'd0);

    // Single-word ADD leaves word 1 untouched.
    run_cmd(OP_LOAD, 2'd0, trk(29'h155, 29'h5), len);
    run_cmd(OP_ADD, 2'd1, trk(29'h0, 29'h3), len);
    check("add_exec_len",  64'(len), 64'd29);
    check("add_carry_out", 64'(carry_out), 64'd0);
    check("add_ovf",       64'(ovf), 64'd0);
    read_track(v);
    check("add_5_3", 64'(v), 64'(trk(29'h155, 29'h8)));

    // 8 - 9 borrows; 8 - 8 gives zero with no borrow.
    run_cmd(OP_SUB, 2'd1, trk(29'h0, 29'h9), len);
    check("sub_borrow_carry", 64'(carry_out), 64'd0);
    check("sub_borrow_ovf",   64'(ovf), 64'd0);
    check("sub_borrow_zero",  64'(acc_zero), 64'd0);
    read_track(v);
    check("sub_8_9", 64'(v), 64'(trk(29'h155, 29'h1FFFFFFF)));
    run_cmd(OP_LOAD, 2'd1, trk(29'h0, 29'h8), len);
    run_cmd(OP_SUB, 2'd1, trk(29'h0, 29'h8), len);
    check("sub_zero_carry", 64'(carry_out), 64'd1);
    check("sub_zero_ovf",   64'(ovf), 64'd0);
    check("sub_zero_flag",  64'(acc_zero), 64'(ZD_EN));
    read_track(v);
    check("sub_8_8", 64'(v), 64'(trk(29'h155, 29'h0)));

    // Multi-precision carry from word 0 into word 1.
    run_cmd(OP_LOAD, 2'd0, trk(29'h0, 29'h1FFFFFFF), len);
    run_cmd(OP_ADD, 2'd2, trk(29'h0, 29'h1), len);
    check("add2_carry_out", 64'(carry_out), 64'd0);
    check("add2_ovf",       64'(ovf), 64'd0);
    read_track(v);
    check("add2_track", 64'(v), 64'(trk(29'h1, 29'h0)));

    // Signed overflow into the sign bit.
    run_cmd(OP_LOAD, 2'd1, trk(29'h0, 29'h0FFFFFFF), len);
    run_cmd(OP_ADD, 2'd1, trk(29'h0, 29'h1), len);
    check("ovf_set",       64'(ovf), 64'd1);
    check("ovf_carry_out", 64'(carry_out), 64'd0);
    read_track(v);
    check("ovf_track", 64'(v), 64'(trk(29'h1, 29'h10000000)));

    // Shifts, per word only.
    run_cmd(OP_SHR, 2'd1, '0, len);
    check("shr_ovf_cleared", 64'(ovf), 64'd0);
    read_track(v);
    check("shr_sign_fill", 64'(v), 64'(trk(29'h1, 29'h18000000)));
    run_cmd(OP_LOAD, 2'd1, trk(29'h0, 29'h10000000), len);
    run_cmd(OP_SHRL, 2'd1, '0, len);
    read_track(v);
    check("shrl_zero_fill", 64'(v), 64'(trk(29'h1, 29'h08000000)));
    run_cmd(OP_LOAD, 2'd0, trk(29'h1, 29'h6), len);
    run_cmd(OP_SHR, 2'd0, '0, len);
    read_track(v);
    check("shr_6_and_1", 64'(v), 64'(trk(29'h0, 29'h3)));

    // Reset in the middle of an ADD aborts it.
    run_cmd(OP_LOAD, 2'd0, trk(29'h3, 29'h7), len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_words = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c <= N && !found; c++) begin
      @(negedge clk);
      if (bit_pos == '0 && word_pos == '0) found = 1'b1;
    end
    check("mid_exec_origin", 64'(found), 64'd1);
    repeat (10) @(negedge clk);
    ser_in = 1'b1;
    rst    = 1'b1;
    #1;
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_done",  64'(done), 64'd0);
    @(negedge clk);
    check("mid_rst_bit_pos",  64'(bit_pos), 64'd0);
    check("mid_rst_word_pos", 64'(word_pos), 64'd0);
    rst    = 1'b0;
    ser_in = 1'b0;
    dn = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_rst_no_done", 64'(dn), 64'd0);
    read_track(v);
    check("mid_rst_track", 64'(v), 64'd0);
    run_cmd(OP_LOAD, 2'd1, trk(29'h0, 29'h5), len);
    read_track(v);
    check("after_rst_load", 64'(v), 64'(trk(29'h0, 29'h5)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
